// File: rtl/blinky_pkg.sv
// Shared constants and elaboration-time helpers for the simulation-scaled blinker.
package blinky_pkg;

  localparam int unsigned DefaultClkFreqHz     = 200;
  localparam int unsigned DefaultBlinkPeriodMs = 1000;

  // Clocks per LED phase: half of (freq * period_ms / 1000).
  function automatic int unsigned half_cycles(input int unsigned freq, input int unsigned ms);
    return (freq * ms) / 2000;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/blinky_tick_gen.sv
// Free-running modulo-HalfCycles counter; tick_o marks the last count of each phase.
module blinky_tick_gen
  import blinky_pkg::*;
#(
  parameter int unsigned HalfCycles = 100
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int unsigned CntW = cnt_width(HalfCycles);
  localparam logic [CntW-1:0] Last = CntW'(HalfCycles - 1);

  if (HalfCycles < 1) begin : g_bad_half
    $error("blinky_tick_gen: HalfCycles must be at least 1");
  end

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (cnt_q == Last) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Gated by reset so the toggle flop never sees a tick on a reset edge.
  assign tick_o = !rst_i && (cnt_q == Last);

endmodule

// File: rtl/blinky_sim_core.sv
// LED blinker top: tick generator plus a toggle flop giving a 50% duty square wave.
module blinky_sim_core
  import blinky_pkg::*;
#(
  parameter int unsigned ClkFreqHz     = DefaultClkFreqHz,
  parameter int unsigned BlinkPeriodMs = DefaultBlinkPeriodMs
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic led_o
);

  localparam longint unsigned Product =
    longint'(ClkFreqHz) * longint'(BlinkPeriodMs);
  localparam int unsigned HalfCycles = half_cycles(ClkFreqHz, BlinkPeriodMs);

  if (Product > 64'h0000_0000_FFFF_FFFF) begin : g_bad_product
    $error("blinky_sim_core: ClkFreqHz*BlinkPeriodMs overflows 32 bits");
  end
  if (HalfCycles < 1) begin : g_bad_half
    $error("blinky_sim_core: derived HalfCycles is 0");
  end

  logic tick;
  logic led_q;

  blinky_tick_gen #(
    .HalfCycles(HalfCycles)
  ) u_tick_gen (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .tick_o(tick)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      led_q <= 1'b0;
    end else if (tick) begin
      led_q <= ~led_q;
    end
  end

  assign led_o = led_q;

endmodule

// File: tb/tb_blinky_sim_core.sv
// Scoreboard bench for blinky_sim_core: default timing, resets in both phases, held reset, HalfCycles=1.
module tb_blinky_sim_core;

  logic clk;
  logic rst;
  logic led;
  logic rst1;
  logic led1;

  int n_cmp = 0;
  int n_err = 0;
  logic exp_q[$];
  logic got;
  logic want;

  blinky_sim_core dut (
    .clk_i(clk),
    .rst_i(rst),
    .led_o(led)
  );

  blinky_sim_core #(
    .ClkFreqHz    (2),
    .BlinkPeriodMs(1000)
  ) dut1 (
    .clk_i(clk),
    .rst_i(rst1),
    .led_o(led1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // LED level after the k-th counting edge following reset release.
  function automatic logic exp_led(input int k, input int h);
    return ((k / h) % 2) == 1;
  endfunction

  // Drive rst away from the active edge, queue the expected LED, sample #1 after the edge.
  task automatic drive(input logic r, input logic w);
    @(negedge clk);
    rst = r;
    exp_q.push_back(w);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0);
      got = led; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL reset_led edge %0d: led=%b expected %b", i, got, want);
      end
    end
    n_cmp++;
    if (dut.u_tick_gen.cnt_q !== 7'd0) begin
      n_err++; $display("FAIL reset_cnt: cnt=%0d expected 0", dut.u_tick_gen.cnt_q);
    end
  endtask

  task automatic test_blink();
    for (int k = 1; k <= 1000; k++) begin
      drive(1'b0, exp_led(k, 100));
      got = led; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL blink edge %0d: led=%b expected %b", k, got, want);
      end
    end
  endtask

  task automatic test_reset_off_phase();
    drive(1'b1, 1'b0);
    got = led; want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin
      n_err++; $display("FAIL off_pre_reset: led=%b expected %b", got, want);
    end
    for (int k = 1; k <= 50; k++) begin
      drive(k == 50, (k == 50) ? 1'b0 : exp_led(k, 100));
      got = led; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL off_phase edge %0d: led=%b expected %b", k, got, want);
      end
    end
    for (int k = 1; k <= 100; k++) begin
      drive(1'b0, exp_led(k, 100));
      got = led; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL off_restart edge %0d: led=%b expected %b", k, got, want);
      end
    end
  endtask

  task automatic test_reset_on_phase();
    drive(1'b1, 1'b0);
    got = led; want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin
      n_err++; $display("FAIL on_pre_reset: led=%b expected %b", got, want);
    end
    for (int k = 1; k <= 150; k++) begin
      drive(k == 150, (k == 150) ? 1'b0 : exp_led(k, 100));
      got = led; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL on_phase edge %0d: led=%b expected %b", k, got, want);
      end
    end
    for (int k = 1; k <= 120; k++) begin
      drive(1'b0, exp_led(k, 100));
      got = led; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL on_restart edge %0d: led=%b expected %b", k, got, want);
      end
    end
  endtask

  task automatic test_held_reset();
    for (int i = 1; i <= 300; i++) begin
      drive(1'b1, 1'b0);
      got = led; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL held_led edge %0d: led=%b expected %b", i, got, want);
      end
      n_cmp++;
      if (dut.u_tick_gen.tick_o !== 1'b0) begin
        n_err++; $display("FAIL held_tick edge %0d: tick=%b expected 0", i, dut.u_tick_gen.tick_o);
      end
    end
    for (int k = 1; k <= 200; k++) begin
      drive(1'b0, exp_led(k, 100));
      got = led; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL held_release edge %0d: led=%b expected %b", k, got, want);
      end
    end
  endtask

  task automatic test_half_one();
    logic [3:0] pattern;
    pattern = 4'b0101;
    @(negedge clk);
    rst1 = 1'b1;
    exp_q.push_back(1'b0);
    @(posedge clk);
    #1;
    got = led1; want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin
      n_err++; $display("FAIL half1_reset: led=%b expected %b", got, want);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      rst1 = 1'b0;
      exp_q.push_back(pattern[k-1]);
      @(posedge clk);
      #1;
      got = led1; want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL half1_toggle edge %0d: led=%b expected %b", k, got, want);
      end
    end
    n_cmp++;
    if (dut1.u_tick_gen.cnt_q !== 1'b0) begin
      n_err++; $display("FAIL half1_cnt: cnt=%0d expected 0", dut1.u_tick_gen.cnt_q);
    end
  endtask

  initial begin
    rst  = 1'b1;
    rst1 = 1'b1;
    test_reset();
    test_blink();
    test_reset_off_phase();
    test_reset_on_phase();
    test_held_reset();
    test_half_one();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
